// File: rtl/umi_crossbar_rr_pkg.sv
// Shared constants and the one-hot mux helper for the UMI round-robin crossbar.
package umi_crossbar_rr_pkg;

  localparam logic [1:0] MODE_PRIO = 2'b00;
  localparam logic [1:0] MODE_RR   = 2'b10;
  localparam int         MUX_MAX_N = 32;

  // One output bit of a one-hot mux: sel is the grant, col holds that bit from every input.
  function automatic logic onehot_mux(input logic [MUX_MAX_N-1:0] sel,
                                      input logic [MUX_MAX_N-1:0] col);
    return |(sel & col);
  endfunction

endpackage

// File: rtl/umi_crossbar_rr_if.sv
// Bundled UMI crossbar bus: N host-side input ports and M device-side output ports.
interface umi_crossbar_rr_if #(
  parameter int N  = 4,
  parameter int M  = 4,
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 256
);
  logic [1:0]      mode;
  logic [N*M-1:0]  mask;
  logic [N*M-1:0]  umi_in_request;
  logic [N*CW-1:0] umi_in_cmd;
  logic [N*AW-1:0] umi_in_dstaddr;
  logic [N*AW-1:0] umi_in_srcaddr;
  logic [N*DW-1:0] umi_in_data;
  logic [N-1:0]    umi_in_ready;
  logic [M-1:0]    umi_out_valid;
  logic [M-1:0]    umi_out_ready;
  logic [M*CW-1:0] umi_out_cmd;
  logic [M*AW-1:0] umi_out_dstaddr;
  logic [M*AW-1:0] umi_out_srcaddr;
  logic [M*DW-1:0] umi_out_data;

  modport master (
    output mode, mask, umi_in_request, umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr,
           umi_in_data, umi_out_ready,
    input  umi_in_ready, umi_out_valid, umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr,
           umi_out_data
  );

  modport slave (
    input  mode, mask, umi_in_request, umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr,
           umi_in_data, umi_out_ready,
    output umi_in_ready, umi_out_valid, umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr,
           umi_out_data
  );
endinterface

// File: rtl/umi_crossbar_rr_arb.sv
// Per-output arbiter: fixed-priority or round-robin pick with a grant lock while the output stalls.
// UMI_CROSSBAR_OUTREG_EN disables the lock (the output register holds the packet instead).
module umi_crossbar_rr_arb
  import umi_crossbar_rr_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         take,
  output logic [N-1:0] gnt,
  output logic [N-1:0] sel,
  output logic         valid
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_r, lock_idx_r, start_s, idx_s, srch_idx_s, win_idx_s, ptr_nxt_s;
  logic [IW:0]   sum_s;
  logic          lock_r, srch_any_s, any_s, rr_s, hs_s;
  logic [N-1:0]  elig_s, eff_s;

  // Winner search from the start point; smallest offset wins, so scan offsets downwards.
  always_comb begin
    rr_s       = ((mode & MODE_RR) != MODE_PRIO);
    elig_s     = req & ~mask & {N{en}};
    eff_s      = lock_r ? req : elig_s;
    start_s    = rr_s ? ptr_r : '0;
    sum_s      = '0;
    idx_s      = '0;
    srch_idx_s = '0;
    srch_any_s = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      sum_s      = {1'b0, start_s} + (IW + 1)'(off);
      idx_s      = (sum_s >= (IW + 1)'(N)) ? IW'(sum_s - (IW + 1)'(N)) : IW'(sum_s);
      srch_idx_s = elig_s[idx_s] ? idx_s : srch_idx_s;
      srch_any_s = srch_any_s | elig_s[idx_s];
    end
    win_idx_s = lock_r ? lock_idx_r : srch_idx_s;
    any_s     = lock_r | srch_any_s;
    gnt       = any_s ? (N'(1) << win_idx_s) : '0;
    sel       = gnt & eff_s;
    valid     = |sel;
    hs_s      = valid & take;
    ptr_nxt_s = (win_idx_s == IW'(N - 1)) ? '0 : win_idx_s + IW'(1);
  end

  // Pointer moves only on a handshake; lock freezes the grant while valid waits for ready.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ptr_r      <= '0;
      lock_r     <= 1'b0;
      lock_idx_r <= '0;
    end else begin
      ptr_r      <= hs_s ? ptr_nxt_s : ptr_r;
`ifdef UMI_CROSSBAR_OUTREG_EN
      lock_r     <= 1'b0;
`else
      lock_r     <= valid & ~take;
`endif
      lock_idx_r <= win_idx_s;
    end
  end

endmodule

// File: rtl/umi_crossbar_rr.sv
// NxM UMI crossbar with per-output arbitration, masking and valid-hold grant lock.
// UMI_CROSSBAR_OUTREG_EN adds one register stage per output (latency 1, full throughput).
module umi_crossbar_rr
  import umi_crossbar_rr_pkg::*;
#(
  parameter int N  = 4,
  parameter int M  = 4,
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 256
) (
  input logic              clk,
  input logic              nreset,
  umi_crossbar_rr_if.slave bus
);
  localparam int FW = CW + 2 * AW + DW;

  logic          run_r;
  logic [N-1:0]  req_s  [M];
  logic [N-1:0]  mask_s [M];
  logic [N-1:0]  gnt_s  [M];
  logic [N-1:0]  sel_s  [M];
  logic [M-1:0]  valid_s, take_s;
  logic [N-1:0]  ready_s;
  logic [FW-1:0] fld_s  [N];

  // Release from reset is synchronous: outputs stay quiet until the first clock after nreset rises.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  // Transpose request/mask to per-output columns and pack each input's fields.
  always_comb begin
    for (int j = 0; j < M; j++) begin
      for (int i = 0; i < N; i++) begin
        req_s[j][i]  = bus.umi_in_request[i*M+j];
        mask_s[j][i] = bus.mask[i*M+j];
      end
    end
    for (int i = 0; i < N; i++) begin
      fld_s[i] = {bus.umi_in_cmd[i*CW +: CW], bus.umi_in_dstaddr[i*AW +: AW],
                  bus.umi_in_srcaddr[i*AW +: AW], bus.umi_in_data[i*DW +: DW]};
    end
  end

  for (genvar j = 0; j < M; j++) begin : g_out
    logic [MUX_MAX_N-1:0] sel_ext_s, col_s;
    logic [FW-1:0]        mux_s, out_fld_s;
    logic                 out_valid_s;

    umi_crossbar_rr_arb #(.N(N)) u_arb (
      .clk   (clk),
      .nreset(nreset),
      .en    (run_r),
      .mode  (bus.mode),
      .req   (req_s[j]),
      .mask  (mask_s[j]),
      .take  (take_s[j]),
      .gnt   (gnt_s[j]),
      .sel   (sel_s[j]),
      .valid (valid_s[j])
    );

    // Bit-sliced one-hot mux; an empty select yields all-zero fields.
    always_comb begin
      sel_ext_s        = '0;
      sel_ext_s[N-1:0] = sel_s[j];
      col_s            = '0;
      mux_s            = '0;
      for (int b = 0; b < FW; b++) begin
        for (int i = 0; i < N; i++) begin
          col_s[i] = fld_s[i][b];
        end
        mux_s[b] = onehot_mux(sel_ext_s, col_s);
      end
    end

`ifdef UMI_CROSSBAR_OUTREG_EN
    logic          oreg_valid_r;
    logic [FW-1:0] oreg_fld_r;

    // Output stage reloads whenever it is empty or being drained this cycle.
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        oreg_valid_r <= 1'b0;
        oreg_fld_r   <= '0;
      end else if (take_s[j]) begin
        oreg_valid_r <= valid_s[j];
        oreg_fld_r   <= mux_s;
      end
    end

    assign take_s[j]   = ~oreg_valid_r | bus.umi_out_ready[j];
    assign out_valid_s = oreg_valid_r;
    assign out_fld_s   = oreg_fld_r;
`else
    assign take_s[j]   = bus.umi_out_ready[j];
    assign out_valid_s = valid_s[j];
    assign out_fld_s   = mux_s;
`endif

    assign bus.umi_out_valid[j]             = out_valid_s;
    assign bus.umi_out_cmd[j*CW +: CW]      = out_fld_s[FW-1 -: CW];
    assign bus.umi_out_dstaddr[j*AW +: AW]  = out_fld_s[2*AW+DW-1 -: AW];
    assign bus.umi_out_srcaddr[j*AW +: AW]  = out_fld_s[AW+DW-1 -: AW];
    assign bus.umi_out_data[j*DW +: DW]     = out_fld_s[DW-1:0];
  end

  // An input is accepted when an output that granted it can take the packet.
  always_comb begin
    ready_s = '0;
    for (int j = 0; j < M; j++) begin
      ready_s = ready_s | (gnt_s[j] & {N{take_s[j]}});
    end
  end

  assign bus.umi_in_ready = ready_s;

endmodule

// File: tb/tb_umi_crossbar_rr.sv
// Directed bench for umi_crossbar_rr with a per-cycle arbitration model and literal spot checks.
module tb_umi_crossbar_rr;
  import umi_crossbar_rr_pkg::*;

  localparam int N  = 4;
  localparam int M  = 4;
  localparam int CW = 32;
  localparam int AW = 64;
  localparam int DW = 256;
  localparam int FW = CW + 2 * AW + DW;

  logic clk = 1'b0;
  logic nreset;
  int   tests = 0;
  int   fails = 0;

  umi_crossbar_rr_if #(.N(N), .M(M), .CW(CW), .AW(AW), .DW(DW)) bus ();

  umi_crossbar_rr #(.N(N), .M(M), .CW(CW), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .nreset(nreset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] cmd_of(input int i);
    return CW'(32'hC0DE_0000 + i);
  endfunction
  function automatic logic [AW-1:0] dst_of(input int i);
    return {32'hD57A_0000 + 32'(i), 32'h1234_5678};
  endfunction
  function automatic logic [AW-1:0] src_of(input int i);
    return {32'h5AC0_0000 + 32'(i), 32'h9ABC_DEF0};
  endfunction
  function automatic logic [DW-1:0] data_of(input int i);
    logic [31:0] w;
    w = 32'hDA7A_0000 + 32'(i);
    return {8{w}};
  endfunction
  function automatic logic [FW-1:0] fld_of(input int i);
    return {cmd_of(i), dst_of(i), src_of(i), data_of(i)};
  endfunction

  task automatic chk(input string name, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h want %0h", name, got, exp);
    end
  endtask

  // Model: what each output must show, derived from the arbitration rules.
  int  m_ptr [M];
  bit  m_lock[M];
  int  m_lwin[M];
  bit  m_run;
  int  e_win [M];
  bit  e_valid[M];

  function automatic void eval();
    int start;
    int i;
    for (int j = 0; j < M; j++) begin
      e_win[j]   = -1;
      e_valid[j] = 1'b0;
      if (m_run) begin
        if (m_lock[j]) begin
          e_win[j]   = m_lwin[j];
          e_valid[j] = bus.umi_in_request[m_lwin[j]*M+j];
        end else begin
          start = bus.mode[1] ? m_ptr[j] : 0;
          for (int off = 0; off < N; off++) begin
            i = (start + off) % N;
            if (e_win[j] < 0 && bus.umi_in_request[i*M+j] && !bus.mask[i*M+j]) e_win[j] = i;
          end
          e_valid[j] = (e_win[j] >= 0);
        end
      end
    end
  endfunction

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_run <= 1'b0;
      for (int j = 0; j < M; j++) begin
        m_ptr[j]  <= 0;
        m_lock[j] <= 1'b0;
        m_lwin[j] <= 0;
      end
    end else if (!m_run) begin
      m_run <= 1'b1;
    end else begin
      eval();
      for (int j = 0; j < M; j++) begin
        if (e_valid[j] && bus.umi_out_ready[j]) m_ptr[j] <= (e_win[j] == N - 1) ? 0 : e_win[j] + 1;
        m_lock[j] <= e_valid[j] && !bus.umi_out_ready[j];
        m_lwin[j] <= e_win[j];
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [N-1:0] exp_rdy;
    eval();
    exp_rdy = '0;
    for (int j = 0; j < M; j++) begin
      if (e_win[j] >= 0 && bus.umi_out_ready[j]) exp_rdy = exp_rdy | (N'(1) << e_win[j]);
    end
    chk("model_in_ready", FW'(bus.umi_in_ready), FW'(exp_rdy));
    for (int j = 0; j < M; j++) begin
      chk($sformatf("model_out_valid[%0d]", j), FW'(bus.umi_out_valid[j]), FW'(e_valid[j]));
      chk($sformatf("model_out_fields[%0d]", j),
          {bus.umi_out_cmd[j*CW +: CW], bus.umi_out_dstaddr[j*AW +: AW],
           bus.umi_out_srcaddr[j*AW +: AW], bus.umi_out_data[j*DW +: DW]},
          e_valid[j] ? fld_of(e_win[j]) : FW'(0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] t1_cmd [5];
  logic [3:0]  t1_rdy [5];

  initial begin
    t1_cmd = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'hC0DE_0000};
    t1_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    nreset             = 1'b0;
    bus.mode           = 2'b10;
    bus.mask           = '0;
    bus.umi_in_request = '0;
    bus.umi_out_ready  = '1;
    for (int i = 0; i < N; i++) begin
      bus.umi_in_cmd[i*CW +: CW]     = cmd_of(i);
      bus.umi_in_dstaddr[i*AW +: AW] = dst_of(i);
      bus.umi_in_srcaddr[i*AW +: AW] = src_of(i);
      bus.umi_in_data[i*DW +: DW]    = data_of(i);
    end
    bus.umi_in_request[0] = 1'b1;
    step(); step();
    @(negedge clk);
    chk("rst_out_valid", FW'(bus.umi_out_valid), FW'(4'b0000));
    chk("rst_in_ready", FW'(bus.umi_in_ready), FW'(4'b0000));
    step();
    nreset             = 1'b1;
    bus.umi_in_request = '0;
    step();

    // Round-robin: all inputs to output 2.
    bus.umi_in_request = 16'h4444;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_cmd_out2", FW'(bus.umi_out_cmd[2*CW +: CW]), FW'(t1_cmd[k]));
      chk("rr_in_ready", FW'(bus.umi_in_ready), FW'(t1_rdy[k]));
      step();
    end
    bus.umi_in_request = '0;

    // Fixed priority (reserved mode bit set): inputs 1 and 3 to output 0.
    bus.mode = 2'b01;
    bus.umi_in_request = 16'h1010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("prio_in_ready", FW'(bus.umi_in_ready), FW'(4'b0010));
      chk("prio_cmd_out0", FW'(bus.umi_out_cmd[0 +: CW]), FW'(32'hC0DE_0001));
      step();
    end
    bus.umi_in_request = '0;

    // Grant lock on output 1: input 2 stalls, input 0 joins, mask on the locked pair ignored.
    bus.mode = 2'b10;
    bus.umi_out_ready = 4'b1101;
    bus.umi_in_request[9] = 1'b1;
    @(negedge clk);
    chk("lock_first_valid", FW'(bus.umi_out_valid[1]), FW'(1'b1));
    step();
    bus.umi_in_request[1] = 1'b1;
    bus.mask[9] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("lock_cmd_out1", FW'(bus.umi_out_cmd[1*CW +: CW]), FW'(32'hC0DE_0002));
      chk("lock_data_out1", FW'(bus.umi_out_data[1*DW +: DW]), FW'({8{32'hDA7A_0002}}));
      chk("lock_in_ready", FW'(bus.umi_in_ready), FW'(4'b0000));
      step();
    end
    bus.umi_out_ready = '1;
    @(negedge clk);
    chk("lock_release_ready", FW'(bus.umi_in_ready), FW'(4'b0100));
    step();
    bus.umi_in_request[9] = 1'b0;
    bus.mask = '0;
    @(negedge clk);
    chk("lock_next_cmd", FW'(bus.umi_out_cmd[1*CW +: CW]), FW'(32'hC0DE_0000));
    chk("lock_next_ready", FW'(bus.umi_in_ready), FW'(4'b0001));
    step();
    bus.umi_in_request = '0;

    // Masked pair never gets through.
    bus.mask[1] = 1'b1;
    bus.umi_in_request[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mask_out_valid1", FW'(bus.umi_out_valid[1]), FW'(1'b0));
      chk("mask_in_ready0", FW'(bus.umi_in_ready[0]), FW'(1'b0));
      step();
    end
    bus.umi_in_request = '0;
    bus.mask = '0;

    // Parallel crossing paths.
    bus.umi_in_request = 16'h1008;
    @(negedge clk);
    chk("par_in_ready", FW'(bus.umi_in_ready), FW'(4'b1001));
    chk("par_out_valid", FW'(bus.umi_out_valid), FW'(4'b1001));
    chk("par_cmd_out3", FW'(bus.umi_out_cmd[3*CW +: CW]), FW'(32'hC0DE_0000));
    chk("par_cmd_out0", FW'(bus.umi_out_cmd[0 +: CW]), FW'(32'hC0DE_0003));
    chk("par_data_out3", FW'(bus.umi_out_data[3*DW +: DW]), FW'({8{32'hDA7A_0000}}));
    step();
    bus.umi_in_request = '0;

    // Reset in the middle of a lock, then round-robin restarts at input 0.
    bus.umi_out_ready = 4'b1011;
    bus.umi_in_request[6] = 1'b1;
    step(); step();
    @(negedge clk);
    chk("rst_lock_cmd", FW'(bus.umi_out_cmd[2*CW +: CW]), FW'(32'hC0DE_0001));
    step();
    nreset = 1'b0;
    #1;
    chk("rst_async_valid", FW'(bus.umi_out_valid), FW'(4'b0000));
    chk("rst_async_ready", FW'(bus.umi_in_ready), FW'(4'b0000));
    step(); step();
    nreset = 1'b1;
    bus.umi_in_request = 16'h4444;
    bus.umi_out_ready = '1;
    @(negedge clk);
    chk("rst_release_valid", FW'(bus.umi_out_valid), FW'(4'b0000));
    step();
    @(negedge clk);
    chk("rst_rr_restart", FW'(bus.umi_out_cmd[2*CW +: CW]), FW'(32'hC0DE_0000));
    chk("rst_rr_ready", FW'(bus.umi_in_ready), FW'(4'b0001));
    step();
    @(negedge clk);
    chk("rst_rr_second", FW'(bus.umi_out_cmd[2*CW +: CW]), FW'(32'hC0DE_0001));
    step();
    bus.umi_in_request = '0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
